trem_mod_sequencer: RTL
=======================

Name: trem_mod_sequencer

Overview:
Controller for the tremolo gain datapath. It owns the LFO, which is a rate divider plus an up/down triangle counter. On each audio_ready strobe it drives a shared external multiplier once per channel using a req/ack handshake, producing the gain-modulated samples y_l/y_r and a one-cycle y_valid. It sits between the codec sample interface and the shared DSP multiplier, and it raises a sticky overrun flag when samples arrive faster than it can sequence them.

Parameters:
DATA_WIDTH, 32, sample width; two's-complement signed.
TRI_W, 8, triangle/gain width.
UPPER_LIMIT, 30, triangle peak value; must be < 2^TRI_W.
DIVIDER, 500000, CLK cycles per triangle step; must be >= 1.

Ports:
CLK  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset.
en  in  1  1 = tremolo active; 0 = bypass.
audio_ready  in  1  new-sample strobe, synchronous to CLK; sampled on its rising edge.
x_l, x_r  in  DATA_WIDTH  input samples; captured on the accepted audio_ready edge.
mul_req  out  1  multiplier request.
mul_a  out  DATA_WIDTH  signed multiplier operand (sample).
mul_b  out  TRI_W+1  multiplier operand (gain, MSB always 0).
mul_ack  in  1  multiplier grant/result valid.
mul_p  in  DATA_WIDTH+TRI_W+1  signed product; valid in the mul_ack cycle.
y_l, y_r  out  DATA_WIDTH  output samples.
y_valid  out  1  one-cycle pulse when y_l/y_r update.
indicator  out  1  LFO phase indicator (drives LED).
busy  out  1  FSM not in IDLE.
overrun  out  1  sticky dropped-sample flag.

Behaviour:
- Reset: all outputs 0; FSM IDLE; triangle tri=0, direction up; divider count 0; captured samples 0.
- LFO, runs only while en=1; en=0 holds tri=0, direction up, divider 0:
  - the divider counts 0..DIVIDER-1; at the terminal count it wraps and tri steps by ±1;
  - at tri=UPPER_LIMIT the direction flips to down; at tri=0 it flips to up; there is no dwell, the sequence is 0,1,..,UL,UL-1,..,0,1.
- indicator is set to 1 when tri==UPPER_LIMIT and cleared to 0 when tri==0; it holds otherwise.
- gain = (2^TRI_W - 1) - tri, zero-extended to TRI_W+1. The gain is latched at sample capture and is constant for both channels of that sample.
- Edge detect: a registered audio_ready_d; accept = audio_ready & ~audio_ready_d.
- FSM states: IDLE, REQ_L, REQ_R, DONE.
  - IDLE: on accept, capture x_l, x_r and gain. If en=1 go to REQ_L; if en=0 load y_l=x_l and y_r=x_r and go to DONE (bypass; no mul_req).
  - REQ_L: mul_req=1, mul_a=x_l, mul_b=gain, operands held stable. On mul_ack, y_l <= mul_p[DATA_WIDTH+TRI_W-1:TRI_W] (arithmetic floor of the shift) and go to REQ_R.
  - REQ_R: same as REQ_L with x_r; result goes to y_r; on mul_ack go to DONE.
  - DONE: y_valid=1 for exactly one cycle, then IDLE.
- mul_req drops in the cycle after mul_ack. Minimum active-path latency from accept to y_valid is 3 cycles with mul_ack tied high. mul_ack while mul_req=0 is ignored.
- An accept while busy=1 is dropped: overrun <= 1 (sticky until reset) and the in-flight sample completes unchanged.
- en changing mid-sequence has no effect on the current sample; it applies at the next capture.
- y_l/y_r hold their values between updates.
- Reset mid-sequence aborts immediately: mul_req=0, y_valid=0.

Optional Feature:
TREM_STEREO_EN
- Defined: behaviour as above; both channels are processed.
- Undefined: REQ_R is removed (REQ_L → DONE), y_r is constantly 0, x_r is ignored, and active-path latency drops to 2 cycles with ack tied high. In bypass y_r is also 0.

Test Plan:
- Reset values: TRI_W=8, UL=3, DIVIDER=4, stereo, en=1, mul_ack=1 → after rst release all outputs are 0.
- Basic multiply: audio_ready pulse with x_l=1000, x_r=-1000, tri=0 → mul_b=255; y_l=996, y_r=-997; y_valid pulses exactly 3 cycles after the edge.
- LFO sweep: run 48 CLK with en=1 → tri steps every 4 clocks through 0,1,2,3,2,1,0; indicator rises at tri=3 and falls at tri=0. A capture at tri=3 with x_l=1000 → y_l=984.
- Handshake stall: mul_ack held low 5 cycles in REQ_L → mul_req, mul_a and mul_b stay stable; y_valid arrives 8 cycles after the edge; y_l is correct.
- Overrun: a second audio_ready edge while in REQ_R → overrun=1 and stays 1; y_valid pulses once; y values are from the first sample.
- Bypass and reset: en=0 with x_l=7, x_r=-7 → y_l=7, y_r=-7, no mul_req. Asserting rst low during REQ_L → mul_req=0 and the FSM is IDLE in the same cycle.

Source files
------------

// File: rtl/trem_mod_sequencer.sv
// rtl/trem_mod_sequencer.sv - tremolo LFO and shared-multiplier gain sequencer; TREM_STEREO_EN enables the right channel
module trem_mod_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int TRI_W       = 8,
    parameter int UPPER_LIMIT = 30,
    parameter int DIVIDER     = 500000
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        audio_ready,
    input  logic [DATA_WIDTH-1:0]       x_l,
    input  logic [DATA_WIDTH-1:0]       x_r,
    output logic                        mul_req,
    output logic [DATA_WIDTH-1:0]       mul_a,
    output logic [TRI_W:0]              mul_b,
    input  logic                        mul_ack,
    input  logic [DATA_WIDTH+TRI_W:0]   mul_p,
    output logic [DATA_WIDTH-1:0]       y_l,
    output logic [DATA_WIDTH-1:0]       y_r,
    output logic                        y_valid,
    output logic                        indicator,
    output logic                        busy,
    output logic                        overrun
);

    localparam int              DIV_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
    localparam logic [TRI_W-1:0] TRI_PEAK = TRI_W'(UPPER_LIMIT);
    localparam logic [TRI_W-1:0] GAIN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_L = 2'd1,
        REQ_R = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic [TRI_W-1:0]        tri_val;
    logic                    dir_up;
    logic                    step_up;
    logic                    audio_ready_d;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   xl_q;
    logic [TRI_W-1:0]        gain_q;
    logic [DATA_WIDTH-1:0]   prod_scaled;
    logic                    unused_bits;
`ifdef TREM_STEREO_EN
    logic [DATA_WIDTH-1:0]   xr_q;
`endif

    assign accept      = audio_ready & ~audio_ready_d;
    // direction for the next step: reverse at the peak going up and at zero going down
    assign step_up     = dir_up ? (tri_val != TRI_PEAK) : (tri_val == '0);
    // dropping the low TRI_W bits of a two's-complement product is a floor divide
    assign prod_scaled = mul_p[DATA_WIDTH+TRI_W-1:TRI_W];
    assign busy        = (state != IDLE);

    // LFO: rate divider plus up/down triangle, parked at zero while bypassed
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tri_val <= '0;
            dir_up  <= 1'b1;
        end else if (!en) begin
            div_cnt <= '0;
            tri_val <= '0;
            dir_up  <= 1'b1;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dir_up  <= step_up;
            tri_val <= step_up ? tri_val + 1'b1 : tri_val - 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // LED phase indicator: set at the peak, cleared at zero, held in between
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            indicator <= 1'b0;
        end else if (tri_val == TRI_PEAK) begin
            indicator <= 1'b1;
        end else if (tri_val == '0) begin
            indicator <= 1'b0;
        end
    end

    // strobe edge detect and sticky record of samples dropped while busy
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            audio_ready_d <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            audio_ready_d <= audio_ready;
            if (accept && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // sample/gain capture and left result register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            xl_q   <= '0;
            gain_q <= '0;
            y_l    <= '0;
        end else begin
            if ((state == IDLE) && accept) begin
                xl_q   <= x_l;
                gain_q <= GAIN_MAX - tri_val;
                if (!en) begin
                    y_l <= x_l;
                end
            end
            if ((state == REQ_L) && mul_ack) begin
                y_l <= prod_scaled;
            end
        end
    end

`ifdef TREM_STEREO_EN
    // right channel capture and result register
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            xr_q <= '0;
            y_r  <= '0;
        end else begin
            if ((state == IDLE) && accept) begin
                xr_q <= x_r;
                if (!en) begin
                    y_r <= x_r;
                end
            end
            if ((state == REQ_R) && mul_ack) begin
                y_r <= prod_scaled;
            end
        end
    end

    assign unused_bits = ^{mul_p[DATA_WIDTH+TRI_W], mul_p[TRI_W-1:0]};
`else
    assign y_r         = '0;
    assign unused_bits = ^{mul_p[DATA_WIDTH+TRI_W], mul_p[TRI_W-1:0], x_r};
`endif

    // sequencer state register; reset aborts any request in flight
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and multiplier/valid outputs; operands are held stable while requesting
    always_comb begin
        state_nxt = state;
        mul_req   = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        y_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = en ? REQ_L : DONE;
                end
            end
            REQ_L: begin
                mul_req = 1'b1;
                mul_a   = xl_q;
                mul_b   = {1'b0, gain_q};
                if (mul_ack) begin
`ifdef TREM_STEREO_EN
                    state_nxt = REQ_R;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef TREM_STEREO_EN
            REQ_R: begin
                mul_req = 1'b1;
                mul_a   = xr_q;
                mul_b   = {1'b0, gain_q};
                if (mul_ack) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                y_valid   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
